// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and constants for the multi-cycle MIPS control unit:
//   - mcState_e : controller state encoding (also exported on state_o)
//   - OP_*      : opcode field values (IR[31:26]) the controller decodes
//   - ALUOP_*   : ALUOp codes
//   - SRCB_*    : ALUSrcB mux select codes
//   - PCSRC_*   : PCSource mux select codes
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        TRAP   = 4'd15
    } mcState_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the states that stall on the memory ready handshake.
    function automatic logic isWaitState(input mcState_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// ---------------------------------------------------------------------------
// mc_wait_timer
// Counts consecutive stalled cycles in a memory-wait state and flags the
// cycle on which the stall reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0
// disables the timeout (expired is tied low).
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, clears the count
//   clear   in   clear the count this edge (takes priority over tick)
//   tick    in   one stalled cycle; increments the count
//   expired out  tick is high and this is the TIMEOUT_CYCLES-th stalled cycle
// ---------------------------------------------------------------------------
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    generate
        if (TIMEOUT_CYCLES == 0) begin : gNoTimeout
            logic unusedInputs;
            assign unusedInputs = ^{clk, rst, clear, tick};
            assign expired      = 1'b0;
        end else begin : gTimeout
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    count <= '0;
                end else if (tick) begin
                    count <= count + CW'(1);
                end
            end

            // Count holds the number of stalled cycles already seen, so the
            // current cycle is the last allowed one when count == LAST.
            assign expired = tick && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle MIPS control unit. Sequences the shared datapath over 3-5
// cycles per instruction with Moore outputs decoded from the state register.
// Memory-wait states (FETCH, MEMRD, MEMWR) stall on mem_ready; a stall of
// TIMEOUT_CYCLES consecutive cycles drops the controller into TRAP, which
// holds until rst.
//
// Build option: define MC_JUMP_EN to add the JUMP state (opcode 2).
// Without it opcode 2 traps and PCSource never takes the jump code.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   opcode[5:0]  in   IR[31:26]
//   mem_ready    in   memory completed the current access this cycle
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load qualified by ALU zero
//   IorD         out  memory address select (0 PC, 1 ALUOut)
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   IRWrite      out  load IR from memory data
//   MemtoReg     out  register write data select (0 ALUOut, 1 MDR)
//   RegDst       out  destination select (0 rt, 1 rd)
//   RegWrite     out  register file write enable
//   ALUSrcA      out  ALU A select (0 PC, 1 A)
//   ALUSrcB[1:0] out  ALU B select
//   ALUOp[1:0]   out  ALU operation class
//   PCSource[1:0]out  PC source select
//   instr_done   out  pulse on the last cycle of each instruction
//   fault        out  high while in TRAP
//   state_o[3:0] out  current state, for debug
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory ready
// DECODE | register read, branch target into ALUOut
// MEMADR | load/store effective address
// MEMRD  | load data read, waits on memory
// MEMWB  | load write-back to rt
// MEMWR  | store data write, waits on memory
// EXEC   | R-type ALU operation
// ALUWB  | R-type write-back to rd
// BRANCH | beq compare and conditional PC load
// JUMP   | jump PC load (MC_JUMP_EN builds only)
// TRAP   | illegal opcode/state or memory timeout, holds until rst
// ---------------------------------------------------------------------------
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state_o
);

    mcState_e state;
    mcState_e nextState;

    logic waitState;
    logic timerClear;
    logic timerTick;
    logic timedOut;

    // Write enables before reset gating.
    logic pcWriteRaw;
    logic pcWriteCondRaw;
    logic memWriteRaw;
    logic irWriteRaw;
    logic regWriteRaw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // The count only matters while stalled in a wait state. Clearing it in
    // every non-wait cycle means it is already zero on entry to the next
    // wait state, and the only way out of a wait state with mem_ready low is
    // the timeout itself, so no separate state-change detect is needed.
    assign waitState  = isWaitState(state);
    assign timerTick  = waitState && !mem_ready;
    assign timerClear = !waitState || mem_ready;

    mc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWaitTimer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timerClear),
        .tick   (timerTick),
        .expired(timedOut)
    );

    always_comb begin
        nextState      = state;
        pcWriteRaw     = 1'b0;
        pcWriteCondRaw = 1'b0;
        memWriteRaw    = 1'b0;
        irWriteRaw     = 1'b0;
        regWriteRaw    = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemtoReg       = 1'b0;
        RegDst         = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = SRCB_REG;
        ALUOp          = ALUOP_ADD;
        PCSource       = PCSRC_ALU;
        instr_done     = 1'b0;
        fault          = 1'b0;

        case (state)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                if (mem_ready) begin
                    irWriteRaw = 1'b1;
                    pcWriteRaw = 1'b1;
                    nextState  = DECODE;
                end else if (timedOut) begin
                    nextState = TRAP;
                end
            end

            DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                case (opcode)
                    OP_RTYPE:     nextState = EXEC;
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_BEQ:       nextState = BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         nextState = JUMP;
`endif
                    default:      nextState = TRAP;
                endcase
            end

            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LW:   nextState = MEMRD;
                    OP_SW:   nextState = MEMWR;
                    default: nextState = TRAP;
                endcase
            end

            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nextState = MEMWB;
                end else if (timedOut) begin
                    nextState = TRAP;
                end
            end

            MEMWB: begin
                regWriteRaw = 1'b1;
                MemtoReg    = 1'b1;
                instr_done  = 1'b1;
                nextState   = FETCH;
            end

            MEMWR: begin
                memWriteRaw = 1'b1;
                IorD        = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end else if (timedOut) begin
                    nextState = TRAP;
                end
            end

            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_FUNCT;
                nextState = ALUWB;
            end

            ALUWB: begin
                regWriteRaw = 1'b1;
                RegDst      = 1'b1;
                instr_done  = 1'b1;
                nextState   = FETCH;
            end

            BRANCH: begin
                ALUSrcA        = 1'b1;
                ALUOp          = ALUOP_SUB;
                pcWriteCondRaw = 1'b1;
                PCSource       = PCSRC_ALUOUT;
                instr_done     = 1'b1;
                nextState      = FETCH;
            end

`ifdef MC_JUMP_EN
            JUMP: begin
                pcWriteRaw = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                nextState  = FETCH;
            end
`endif

            TRAP: begin
                fault     = 1'b1;
                nextState = TRAP;
            end

            // Unused encodings (and JUMP when it is not built) are treated
            // as corruption and park in TRAP with all outputs quiet.
            default: begin
                nextState = TRAP;
            end
        endcase
    end

    // Architectural write enables are forced low during the reset cycle so a
    // reset arriving mid-instruction cannot leave a partial write behind.
    assign PCWrite     = pcWriteRaw     && !rst;
    assign PCWriteCond = pcWriteCondRaw && !rst;
    assign MemWrite    = memWriteRaw    && !rst;
    assign IRWrite     = irWriteRaw     && !rst;
    assign RegWrite    = regWriteRaw    && !rst;

    assign state_o = state;

endmodule
